// File: rtl/branch_loop_counter_pkg.sv
// Shared definitions for the per-thread branch loop counter.
//   DEF_THREAD_COUNT / DEF_THREAD_WIDTH / DEF_COUNT_WIDTH : default geometry
//   cfg_sel_e : configuration port target select (live count or reload value)
package branch_loop_counter_pkg;

  localparam int unsigned DEF_THREAD_COUNT = 8;
  localparam int unsigned DEF_THREAD_WIDTH = 3;
  localparam int unsigned DEF_COUNT_WIDTH  = 16;

  typedef enum logic {
    CFG_COUNT  = 1'b0,
    CFG_RELOAD = 1'b1
  } cfg_sel_e;

endpackage

// File: rtl/branch_loop_counter_entry.sv
// One thread's loop counter state: live count, reload value and zero flag.
//   clock, reset_n   : clock and asynchronous active-low reset
//   hit_en           : branch origin hit for this thread this cycle
//   cfg_count_we     : configuration write to the live count
//   cfg_reload_we    : configuration write to the reload value
//   cfg_data         : configuration write data
//   nonzero          : live count is non-zero (decision for a hit this cycle)
//   zero             : registered flag, stored count == 0
module branch_loop_counter_entry
  import branch_loop_counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   hit_en,
  input  logic                   cfg_count_we,
  input  logic                   cfg_reload_we,
  input  logic [COUNT_WIDTH-1:0] cfg_data,
  output logic                   nonzero,
  output logic                   zero
);

  logic [COUNT_WIDTH-1:0] count_q,  count_d;
  logic [COUNT_WIDTH-1:0] reload_q, reload_d;
  logic                   zero_q,   zero_d;

  assign nonzero = (count_q != '0);
  assign zero    = zero_q;

  // Hit update first, config write overrides the stored count afterwards.
  // Reload on fall-through uses reload_q, so a same-cycle reload write only
  // affects the next re-arm.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (hit_en) begin
      if (nonzero) begin
        count_d = count_q - 1'b1;
      end else begin
        count_d = reload_q;
      end
    end
    if (cfg_count_we) begin
      count_d = cfg_data;
    end
    if (cfg_reload_we) begin
      reload_d = cfg_data;
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      reload_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: rtl/branch_loop_counter.sv
// Per-thread counted-loop branch resolver sitting after the branch-origin check.
//   clock, reset_n : clock and asynchronous active-low reset
//   hit, hit_thread: registered origin-match and its owning thread
//   cfg_we, cfg_thread, cfg_sel, cfg_data : configuration write port
//   taken, taken_valid, taken_thread : registered loop decision (1-cycle latency)
//   zero           : per-thread registered flag, stored count == 0
module branch_loop_counter
  import branch_loop_counter_pkg::*;
#(
  parameter int unsigned THREAD_COUNT = DEF_THREAD_COUNT,
  parameter int unsigned THREAD_WIDTH = DEF_THREAD_WIDTH,
  parameter int unsigned COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    hit,
  input  logic [THREAD_WIDTH-1:0] hit_thread,
  input  logic                    cfg_we,
  input  logic [THREAD_WIDTH-1:0] cfg_thread,
  input  logic                    cfg_sel,
  input  logic [COUNT_WIDTH-1:0]  cfg_data,
  output logic                    taken,
  output logic                    taken_valid,
  output logic [THREAD_WIDTH-1:0] taken_thread,
  output logic [THREAD_COUNT-1:0] zero
);

  logic [THREAD_COUNT-1:0] hit_vec;
  logic [THREAD_COUNT-1:0] cfg_count_vec;
  logic [THREAD_COUNT-1:0] cfg_reload_vec;
  logic [THREAD_COUNT-1:0] nonzero_vec;

  logic                    taken_q,        taken_d;
  logic                    taken_valid_q,  taken_valid_d;
  logic [THREAD_WIDTH-1:0] taken_thread_q, taken_thread_d;

  always_comb begin
    hit_vec        = '0;
    cfg_count_vec  = '0;
    cfg_reload_vec = '0;
    for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
      hit_vec[t]        = hit && (hit_thread == THREAD_WIDTH'(t));
      cfg_count_vec[t]  = cfg_we && (cfg_thread == THREAD_WIDTH'(t)) &&
                          (cfg_sel == CFG_COUNT);
      cfg_reload_vec[t] = cfg_we && (cfg_thread == THREAD_WIDTH'(t)) &&
                          (cfg_sel == CFG_RELOAD);
    end
  end

  for (genvar g = 0; g < THREAD_COUNT; g++) begin : g_entry
    branch_loop_counter_entry #(
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_entry (
      .clock         (clock),
      .reset_n       (reset_n),
      .hit_en        (hit_vec[g]),
      .cfg_count_we  (cfg_count_vec[g]),
      .cfg_reload_we (cfg_reload_vec[g]),
      .cfg_data      (cfg_data),
      .nonzero       (nonzero_vec[g]),
      .zero          (zero[g])
    );
  end

  // Decision uses the pre-write count, independent of any same-cycle config.
  always_comb begin
    taken_valid_d  = hit;
    taken_d        = hit && nonzero_vec[hit_thread];
    taken_thread_d = hit_thread;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken_q        <= 1'b0;
      taken_valid_q  <= 1'b0;
      taken_thread_q <= '0;
    end else begin
      taken_q        <= taken_d;
      taken_valid_q  <= taken_valid_d;
      taken_thread_q <= taken_thread_d;
    end
  end

  assign taken        = taken_q;
  assign taken_valid  = taken_valid_q;
  assign taken_thread = taken_thread_q;

endmodule

// File: tb/tb_branch_loop_counter.sv
module tb_branch_loop_counter;

  logic        clock;
  logic        reset_n;
  logic        hit;
  logic [2:0]  hit_thread;
  logic        cfg_we;
  logic [2:0]  cfg_thread;
  logic        cfg_sel;
  logic [15:0] cfg_data;
  logic        taken;
  logic        taken_valid;
  logic [2:0]  taken_thread;
  logic [7:0]  zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       taken;
    logic [2:0] thread;
    logic       zero;
  } exp_t;

  exp_t sb[$];

  branch_loop_counter #(
    .THREAD_COUNT (8),
    .THREAD_WIDTH (3),
    .COUNT_WIDTH  (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .hit          (hit),
    .hit_thread   (hit_thread),
    .cfg_we       (cfg_we),
    .cfg_thread   (cfg_thread),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .taken        (taken),
    .taken_valid  (taken_valid),
    .taken_thread (taken_thread),
    .zero         (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation whenever the DUT presents a decision.
  always @(posedge clock) begin
    #2;
    if (taken_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {29'd0, taken_thread}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("taken_t%0d", e.thread), {31'd0, taken}, {31'd0, e.taken});
        chk("taken_thread", {29'd0, taken_thread}, {29'd0, e.thread});
        chk($sformatf("zero_t%0d", e.thread), {31'd0, zero[e.thread]}, {31'd0, e.zero});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input int thr, input logic sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_thread = thr[2:0]; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_hit(input int thr, input logic exp_taken, input logic exp_zero);
    exp_t e;
    hit = 1'b1; hit_thread = thr[2:0];
    e.taken = exp_taken; e.thread = thr[2:0]; e.zero = exp_zero;
    sb.push_back(e);
    tick();
    hit = 1'b0;
  endtask

  task automatic hit_cfg(input int thr, input int cthr, input logic sel, input logic [15:0] data,
                         input logic exp_taken, input logic exp_zero);
    cfg_we = 1'b1; cfg_thread = cthr[2:0]; cfg_sel = sel; cfg_data = data;
    do_hit(thr, exp_taken, exp_zero);
    cfg_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; hit = 1'b0; hit_thread = '0;
    cfg_we = 1'b0; cfg_thread = '0; cfg_sel = 1'b0; cfg_data = '0;
    #12;
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_valid", {31'd0, taken_valid}, 32'd0);
    chk("rst_thread", {29'd0, taken_thread}, 32'd0);
    chk("rst_zero", {24'd0, zero}, 32'h0000_00FF);
    tick();
    reset_n = 1'b1;
    tick();

    // Reload 3 on thread 2: 0,1,1,1,0 with zero 0,0,0,1,0
    do_cfg(2, 1'b1, 16'd3);
    do_hit(2, 1'b0, 1'b0);
    do_hit(2, 1'b1, 1'b0);
    do_hit(2, 1'b1, 1'b0);
    do_hit(2, 1'b1, 1'b1);
    do_hit(2, 1'b0, 1'b0);

    // Config count wins over same-cycle hit on thread 5
    do_cfg(5, 1'b0, 16'd4);
    hit_cfg(5, 5, 1'b0, 16'd1, 1'b1, 1'b0);
    do_hit(5, 1'b1, 1'b1);
    do_hit(5, 1'b0, 1'b1);

    // Round-robin with count[t] = t
    for (int t = 0; t < 8; t++) do_cfg(t, 1'b0, 16'(t));
    for (int t = 0; t < 8; t++) do_hit(t, t != 0, t <= 1);
    for (int t = 0; t < 8; t++) do_hit(t, t >= 2, t <= 2);

    // Idle: counts now 0,0,0,1,2,3,4,5
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", {31'd0, taken_valid}, 32'd0);
      chk("idle_zero", {24'd0, zero}, 32'h0000_0007);
    end
    do_hit(7, 1'b1, 1'b0);

    // Asynchronous reset mid-loop on thread 1
    do_cfg(1, 1'b0, 16'd7);
    do_hit(1, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_taken", {31'd0, taken}, 32'd0);
    chk("async_valid", {31'd0, taken_valid}, 32'd0);
    chk("async_thread", {29'd0, taken_thread}, 32'd0);
    chk("async_zero", {24'd0, zero}, 32'h0000_00FF);
    tick();
    reset_n = 1'b1;
    tick();
    do_hit(1, 1'b0, 1'b1);

    // Max reload, no wrap
    do_cfg(3, 1'b1, 16'hFFFF);
    do_hit(3, 1'b0, 1'b0);
    do_hit(3, 1'b1, 1'b0);

    // Same-cycle reload write at count 0: old reload (5) loads, new (9) stored
    do_cfg(4, 1'b1, 16'd5);
    hit_cfg(4, 4, 1'b1, 16'd9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_hit(4, 1'b1, i == 4);
    do_hit(4, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) do_hit(4, 1'b1, i == 8);

    // Config write to another thread does not disturb the hit
    hit_cfg(6, 0, 1'b0, 16'd2, 1'b0, 1'b1);
    do_hit(0, 1'b1, 1'b0);

    repeat (3) tick();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("missing_decision", 32'd0, {29'd0, e.thread} + 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_loop_counter.md
# branch_loop_counter

Per-thread loop counter that sits directly downstream of the branch-origin check. It consumes the registered `hit` for the thread currently in the branch stage and decides whether a counted loop branch is taken. It then decrements or reloads that thread's counter. The registered `taken` result feeds the PC-select stage; counters and reload values are written through a small configuration port.

## Interface
- `THREAD_COUNT`, 8, number of hardware threads (power of two, ≥2)
- `THREAD_WIDTH`, 3, log2(THREAD_COUNT)
- `COUNT_WIDTH`, 16, counter and reload value width

- `clock` in 1, single clock; all state changes on its rising edge
- `reset_n` in 1, asynchronous, active-low reset
- `hit` in 1, branch origin matched for `hit_thread` (registered output of the origin check)
- `hit_thread` in THREAD_WIDTH, thread owning `hit` this cycle
- `cfg_we` in 1, configuration write strobe
- `cfg_thread` in THREAD_WIDTH, target thread of the configuration write
- `cfg_sel` in 1, 0 = write live count, 1 = write reload value
- `cfg_data` in COUNT_WIDTH, configuration write data
- `taken` out 1, registered: loop branch taken for `taken_thread`
- `taken_valid` out 1, registered: `taken` carries a decision this cycle (delayed `hit`)
- `taken_thread` out THREAD_WIDTH, registered copy of `hit_thread`
- `zero` out THREAD_COUNT, registered per-thread flag: live count == 0

## Operation
- State: `count[t]` and `reload[t]` for each thread t, each COUNT_WIDTH.
- On `hit`=1 for thread t:
  - If `count[t]` ≠ 0: `taken`=1 and `count[t]` ← `count[t]`−1.
  - If `count[t]` == 0: `taken`=0 and `count[t]` ← `reload[t]`. The loop exits and re-arms.
- On `hit`=0: `taken_valid`=0, `taken`=0, and no counter changes. `taken_thread` still tracks `hit_thread`.
- Decrement is unsigned and never wraps. Zero selects reload, so 0−1 never occurs.
- A loop with reload R executes its body R+1 times: R taken, then 1 fall-through.
- Config write: when `cfg_we`=1, the `count` or `reload` entry of `cfg_thread` selected by `cfg_sel` takes `cfg_data`.
- Simultaneous `hit` and config write to the same thread's count: the config write wins for the stored value. `taken` is still computed from the pre-write count.
- Simultaneous `hit` and config write to the same thread's reload while count == 0: the stored count gets the old reload value, and the new reload value is stored.
- Writes to other threads are independent of the hit update.
- `zero[t]` reflects the stored count after the edge.

## Timing
- Latency: `hit` at edge N produces `taken`, `taken_valid` and `taken_thread` valid after edge N+1 (1 cycle).
- Counter update is visible to a new `hit` on the following cycle. Back-to-back hits for the same thread are legal and see the updated count.
- Config write is visible to a `hit` on the next cycle.
- Reset (`reset_n`=0, asynchronous, any time including mid-loop) forces the following:
  - All `count` and `reload` entries are 0.
  - `taken`, `taken_valid` and `taken_thread` are 0.
  - `zero` is all ones.
- Release is synchronous to the next edge. The first hit after reset sees count 0, so it falls through and loads reload 0.
- No handshake or backpressure; the block accepts a decision every cycle.

## Structure
- Shared package holds THREAD_COUNT, THREAD_WIDTH and COUNT_WIDTH defaults, plus the `cfg_sel` encodings (CFG_COUNT=0, CFG_RELOAD=1).
- One natural sub-module, `branch_loop_counter_entry`, instantiated THREAD_COUNT times. It holds one thread's count and reload, the decrement/reload logic, the config priority and the zero flag.
- The top level decodes thread selects and muxes the selected entry's decision into the output registers.

## Test plan
- Reset, write reload[2]=3, then hit thread 2 five times -> `taken` = 0,1,1,1,0; `zero[2]` goes 1→0→0→0→1→0.
- Config count[5]=1 at the same edge as a hit on thread 5 with count 4 -> `taken`=1 and count[5] stores 1, not 3. The next hit gives taken=1, then 0.
- Round-robin hits on threads 0..7, each with count=t -> only thread 0 falls through. Other threads' counts are unchanged except their own decrement.
- `hit`=0 for 10 cycles with config idle -> `taken_valid`=0 and all counts are stable.
- Assert `reset_n` low mid-loop (count[1]=7) between edges -> outputs clear immediately with no clock. After release, the hit on thread 1 gives taken=0.
- Write reload[3]=0xFFFF, hit at count 0 -> reload loads. The next hit gives taken=1 and count 0xFFFE, with no wrap.
